// File: rtl/apb_pkg.sv
// Shared APB types for the requester bridge and the APB slave models.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB3 requester bridge.
// Define APB_MASTER_TIMEOUT_EN to add a watchdog that ends ACCESS stalls after TIMEOUT_CYC cycles.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_state_e state;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int              CNT_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TLIMIT = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] tcnt;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign cmd_ready = (state == IDLE);

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_timeout <= 1'b0;
         tcnt        <= '0;
`endif
      end else begin
         // Response fields only carry meaning during the single-cycle pulse.
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_timeout <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               penable <= 1'b0;
               if (cmd_valid) begin
                  pwrite <= cmd_write;
                  paddr  <= cmd_addr;
                  pwdata <= cmd_wdata;
                  psel   <= 1'b1;
                  state  <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                  tcnt   <= '0;
`endif
               end else begin
                  psel <= 1'b0;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= pslverr;
                  rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               // A real completion in the final allowed cycle takes priority over the watchdog.
               else if (tcnt == TLIMIT) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= IDLE;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed transfers, expected responses queued, monitor compares.
module tb_apb_master_bridge;
   import apb_pkg::*;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 pclk = ~pclk;

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Response monitor: every rsp_valid must match the oldest queued expectation.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge pclk);
         if (rsp_valid === 1'b1) begin
            checkOutput("rsp_single_pulse", {63'd0, prev_valid}, 64'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp actual=rsp_valid expected=none");
            end else begin
               e = exp_q.pop_front();
               checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
               checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
               checkOutput("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.tmo});
            end
         end
         prev_valid = rsp_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   function automatic exp_t mkExp(input apb_cmd_t c, input logic [31:0] rd, input logic err, input logic tmo);
      exp_t e;
      e.err   = err;
      e.tmo   = tmo;
      e.rdata = (!c.write && !err && !tmo) ? rd : 32'd0;
      return e;
   endfunction

   // Runs one full transfer from a negedge in IDLE; slave holds pready low for 'waits' ACCESS cycles.
   task automatic applyStimulus(input apb_cmd_t c, input int waits, input logic [31:0] rd, input logic err);
      checkOutput("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1;
      cmd_write = c.write;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      pready    = 1'b0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      cmd_addr  = ~c.addr;
      cmd_wdata = ~c.wdata;
      checkOutput("setup_psel", {63'd0, psel}, 64'd1);
      checkOutput("setup_penable", {63'd0, penable}, 64'd0);
      checkOutput("setup_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      checkOutput("setup_paddr", {32'd0, paddr}, {32'd0, c.addr});
      checkOutput("setup_pwrite", {63'd0, pwrite}, {63'd0, c.write});
      checkOutput("setup_pwdata", {32'd0, pwdata}, {32'd0, c.wdata});
      @(negedge pclk);
      checkOutput("access_psel", {63'd0, psel}, 64'd1);
      checkOutput("access_penable", {63'd0, penable}, 64'd1);
      for (int w = 0; w < waits; w++) begin
         pready  = 1'b0;
         pslverr = 1'b1;
         prdata  = 32'hBAD0_0000 | w;
         @(negedge pclk);
         checkOutput("wait_penable", {63'd0, penable}, 64'd1);
         checkOutput("wait_pwdata", {32'd0, pwdata}, {32'd0, c.wdata});
         checkOutput("wait_paddr", {32'd0, paddr}, {32'd0, c.addr});
      end
      pready  = 1'b1;
      prdata  = rd;
      pslverr = err;
      exp_q.push_back(mkExp(c, rd, err, 1'b0));
      @(negedge pclk);
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h5A5A_5A5A;
      checkOutput("done_psel", {63'd0, psel}, 64'd0);
      checkOutput("done_penable", {63'd0, penable}, 64'd0);
      checkOutput("done_cmd_ready", {63'd0, cmd_ready}, 64'd1);
   endtask

   initial begin
      apb_cmd_t c, c2;
      int cnt;
      presetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      $display("[TB] reset");
      repeat (2) @(negedge pclk);
      checkOutput("reset_psel", {63'd0, psel}, 64'd0);
      checkOutput("reset_penable", {63'd0, penable}, 64'd0);
      checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      checkOutput("reset_paddr", {32'd0, paddr}, 64'd0);
      checkOutput("reset_pwdata", {32'd0, pwdata}, 64'd0);
      checkOutput("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      presetn = 1'b1;
      @(negedge pclk);

      $display("[TB] write, zero wait states");
      c = '{write: 1'b1, addr: 32'd5, wdata: 32'hDEAD_BEEF};
      applyStimulus(c, 0, 32'h1111_2222, 1'b0);

      $display("[TB] read, two wait states");
      c = '{write: 1'b0, addr: 32'd5, wdata: 32'h0};
      applyStimulus(c, 2, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] read with slave error");
      c = '{write: 1'b0, addr: 32'd40, wdata: 32'h0};
      applyStimulus(c, 0, 32'h1234_5678, 1'b1);

      $display("[TB] write with wait and slave error");
      c = '{write: 1'b1, addr: 32'h100, wdata: 32'h0000_A5A5};
      applyStimulus(c, 1, 32'hFFFF_FFFF, 1'b1);

      $display("[TB] back-to-back commands");
      c  = '{write: 1'b1, addr: 32'h20, wdata: 32'hCAFE_0001};
      c2 = '{write: 1'b0, addr: 32'h24, wdata: 32'h0};
      cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata;
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h0BAD_F00D;
      @(negedge pclk);
      cmd_write = c2.write; cmd_addr = c2.addr; cmd_wdata = c2.wdata;
      checkOutput("b2b_ready_setup", {63'd0, cmd_ready}, 64'd0);
      checkOutput("b2b_paddr_a", {32'd0, paddr}, {32'd0, c.addr});
      exp_q.push_back(mkExp(c, 32'h0BAD_F00D, 1'b0, 1'b0));
      @(negedge pclk);
      checkOutput("b2b_ready_access", {63'd0, cmd_ready}, 64'd0);
      @(negedge pclk);
      checkOutput("b2b_gap_psel", {63'd0, psel}, 64'd0);
      checkOutput("b2b_gap_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      @(negedge pclk);
      cmd_valid = 1'b0;
      checkOutput("b2b_second_psel", {63'd0, psel}, 64'd1);
      checkOutput("b2b_paddr_b", {32'd0, paddr}, {32'd0, c2.addr});
      prdata = 32'h7777_0024;
      exp_q.push_back(mkExp(c2, 32'h7777_0024, 1'b0, 1'b0));
      repeat (2) @(negedge pclk);
      pready = 1'b0;
      checkOutput("b2b_end_psel", {63'd0, psel}, 64'd0);

      $display("[TB] reset during ACCESS wait state");
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      checkOutput("stall_penable", {63'd0, penable}, 64'd1);
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      checkOutput("abort_psel", {63'd0, psel}, 64'd0);
      checkOutput("abort_penable", {63'd0, penable}, 64'd0);
      checkOutput("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      @(negedge pclk);
      c = '{write: 1'b0, addr: 32'h48, wdata: 32'h0};
      applyStimulus(c, 0, 32'h0123_4567, 1'b0);

      $display("[TB] completion in the sixteenth ACCESS cycle");
      c = '{write: 1'b0, addr: 32'h60, wdata: 32'h0};
      applyStimulus(c, 15, 32'h89AB_CDEF, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
      $display("[TB] watchdog on stuck pready");
      c = '{write: 1'b0, addr: 32'h80, wdata: 32'h0};
      exp_q.push_back(mkExp(c, 32'h0, 1'b1, 1'b1));
      cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata;
      pready = 1'b0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100 && psel; i++) begin
         if (penable) cnt++;
         @(negedge pclk);
      end
      checkOutput("timeout_access_cycles", 64'(cnt), 64'd16);
      checkOutput("timeout_psel", {63'd0, psel}, 64'd0);
`else
      $display("[TB] long stall without watchdog");
      c = '{write: 1'b0, addr: 32'h80, wdata: 32'h0};
      applyStimulus(c, 40, 32'h0F0F_F0F0, 1'b0);
      cnt = 0;
      checkOutput("no_timeout_cmd_ready", {63'd0, cmd_ready}, 64'd1);
`endif

      repeat (3) @(negedge pclk);
      checkOutput("pending_rsp", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester. Converts a simple single-outstanding command/response interface into APB3 SETUP/ACCESS transfers.
- Drives the bus toward APB memory-mapped slaves, such as the team's APB RAM.
- Sits between an internal control engine (or testbench driver) and the peripheral APB segment.
- One transfer in flight at a time. Responses return as a one-cycle pulse.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr
- DATA_W, 32, width of write/read data
- TIMEOUT_CYC, 16, max consecutive ACCESS cycles with pready low (used only with the optional feature)

Ports:
- pclk  in  1  clock, all logic on rising edge
- presetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  transfer ended by watchdog
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error, sampled only with pready

Behaviour:
- Reset (presetn = 0 at an edge):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all go to 0. The timeout counter clears.
  - A reset during SETUP or ACCESS abandons the transfer. No rsp_valid is produced.
- States: IDLE, SETUP, ACCESS.
- All bus outputs and rsp_* are registered. cmd_ready = (state == IDLE), combinational from state.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata.
  - Set psel = 1, penable = 0, then go to SETUP.
  - Otherwise psel = penable = 0.
- SETUP: exactly one cycle. Next edge sets penable = 1 and goes to ACCESS.
- ACCESS, pready = 0: hold all bus outputs (wait state).
- ACCESS, pready = 1, at that edge:
  - psel = penable = 0; state goes to IDLE.
  - rsp_valid = 1 for exactly one cycle.
  - rsp_err = pslverr.
  - rsp_rdata = prdata if read and not pslverr, else 0.
- Minimum latency, with acceptance at edge E0: psel high after E0, penable high after E1, rsp_valid high after E2 (zero wait states).
- Throughput: one transfer per 3 cycles minimum. A new command may be accepted on the edge after completion while rsp_valid is still high.
- paddr, pwrite, pwdata stay stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE (not cleared).
- rsp_valid is not back-pressured. The consumer must accept it.
- pslverr and prdata are ignored while pready = 0.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN
- With macro:
  - The counter increments on each ACCESS cycle with pready = 0. It clears on entering SETUP.
  - When TIMEOUT_CYC consecutive low-pready ACCESS cycles have elapsed, the edge ending that cycle terminates the transfer.
  - Termination: psel = penable = 0, IDLE, rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready = 1 in that same cycle, normal completion wins.
  - Counter width: $clog2(TIMEOUT_CYC+1).
- Without macro: no counter. ACCESS waits indefinitely. rsp_timeout is tied to 0.

Decomposition:
- Package apb_pkg holds:
  - enum apb_state_e {IDLE, SETUP, ACCESS}
  - localparams APB_ADDR_W = 32, APB_DATA_W = 32
  - struct apb_cmd_t {write, addr, wdata}
- The slave side shares the same package.
- No sub-module. The FSM and timeout counter are small enough to live inline.

Test Plan:
- Write addr 5, data 0xDEADBEEF, pready tied 1 -> psel after E0, penable after E1, pwdata = 0xDEADBEEF stable, rsp_valid one cycle after E2, rsp_err = 0, rsp_rdata = 0.
- Read addr 5, slave inserts 2 wait states then prdata = 0xDEADBEEF -> penable held 3 cycles, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Read addr 40, slave responds pready = 1, pslverr = 1 -> rsp_err = 1, rsp_rdata = 0, bus returns idle.
- cmd_valid held high for two commands back-to-back -> cmd_ready low during SETUP/ACCESS, second psel rise exactly one cycle after the first rsp_valid edge, no overlap.
- presetn low for 1 cycle during ACCESS wait state -> psel = penable = 0 next cycle, no rsp_valid, next command runs normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 16, pready stuck 0 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err = 1, rsp_timeout = 1.
